fifo_wr_arb: RTL and testbench
==============================

Name: fifo_wr_arb

Overview:
- Round-robin write arbiter that shares one FIFO write port between NUM_REQ producers.
- Sits directly in front of the team's synchronous FIFO. Drives its w_EN, inDvaild and data_in, and watches its full flag.
- A granted producer may write a burst of up to MAX_BURST words before the grant rotates.
- Prevents starvation and guarantees the FIFO never sees a write while full.

Parameters:
- NUM_REQ, 4, number of producers (2..8)
- WIDTH, 8, data word width; must match the FIFO data width
- MAX_BURST, 4, maximum accepted words per grant (>=1)
- TIMEOUT, 16, full-stall cycles before forced release (used only with the optional feature)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-producer write request, level, held until ack
- req_data  in  NUM_REQ*WIDTH  packed producer data, slice i = req_data[i*WIDTH +: WIDTH]
- ack  out  NUM_REQ  one-hot pulse: word of producer i accepted this cycle
- fifo_full  in  1  FIFO full flag
- fifo_w_EN  out  1  FIFO write enable
- fifo_inDvalid  out  1  FIFO data-valid; identical to fifo_w_EN
- fifo_data  out  WIDTH  write data to FIFO
- grant_id  out  $clog2(NUM_REQ)  current grant owner (valid when busy)
- busy  out  1  high in state BURST

Behaviour:
- One clock clk; reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0
  - busy, ack, fifo_w_EN and fifo_inDvalid all 0; fifo_data=0
- FSM states: IDLE, BURST.
- IDLE:
  - If any req, pick the first set req at or after rr_ptr (cyclic search).
  - Register it into grant_id, set burst_cnt=0, go to BURST.
  - No write occurs in IDLE. Arbitration costs exactly one cycle.
- BURST write condition, combinational from registered state: write = req[grant_id] && !fifo_full.
  - fifo_w_EN = fifo_inDvalid = write.
  - ack[grant_id] = write.
  - fifo_data = slice grant_id when busy, else 0.
- burst_cnt increments on each write.
- Exit BURST to IDLE, with rr_ptr <= grant_id+1 (mod NUM_REQ), when either holds:
  - a write occurs and burst_cnt == MAX_BURST-1, or
  - req[grant_id] is low.
- The exit cycle itself may contain the final write.
- Latency: req rises at edge N (arbiter idle) → grant at N+1 → first ack in cycle N+1 if not full.
- Steady-state throughput: one word per cycle within a burst, plus one idle arbitration cycle between bursts.
- fifo_full high in BURST: no write, no ack, burst_cnt holds, grant held. Stall is unbounded without the optional feature.
- Requester drops req mid-burst: release on that edge. Words already acked stay in the FIFO.
- Requests from other producers during a burst are ignored until the next IDLE.
- Fairness: with all req high, grant order is 0,1,2,3,0... and each owner gets exactly MAX_BURST words.
- rr_ptr wraps NUM_REQ-1 → 0. Non-power-of-two NUM_REQ must wrap explicitly, not via width overflow.
- rst asserted mid-burst: all state returns to reset values at that edge. No ack or write in the reset cycle.

Optional Feature:
- Macro: FIFO_WR_ARB_FULL_TIMEOUT_EN.
- When defined:
  - A stall counter counts consecutive BURST cycles with req[grant_id] && fifo_full.
  - It clears on any write or on leaving BURST.
  - When it reaches TIMEOUT-1, release the grant to IDLE and advance rr_ptr as a normal exit.
  - Add output timeout_pulse (1 bit, reset 0), high for the release cycle.
- When undefined: no counter, no timeout_pulse port, and stalls are held indefinitely.

Decomposition:
- Package fifo_arb_pkg holds:
  - typedef enum logic {IDLE, BURST} arb_state_t
  - function rr_next(ptr, n) for modulo increment
- Sub-module rr_pick: purely combinational. Inputs req vector and rr_ptr; outputs winner index and any_req. Parameterized by NUM_REQ.
- All sequential logic stays in fifo_wr_arb.

Test Plan:
- Reset: hold rst 2 cycles with req=4'b1111 → ack=0, fifo_w_EN=0, busy=0, grant_id=0 throughout. First ack[0] arrives 2 cycles after rst falls.
- Fairness: req=4'b1111, fifo_full=0 for 20 cycles, MAX_BURST=4 → 4 acks each, order 0,1,2,3. One idle cycle between bursts; fifo_data equals each producer's slice.
- Early drop: req[2] only, dropped after 2 acks → exactly 2 writes, FSM in IDLE next cycle, rr_ptr=3. A subsequent req=4'b0101 grants 0 (wrap).
- Full stall: fifo_full=1 for 5 cycles mid-burst → no write and no ack while full, grant_id held. The burst resumes and completes its remaining words.
- Reset mid-burst: assert rst after 1 ack of producer 1 → next cycle busy=0, rr_ptr=0, no write in the reset cycle.
- Timeout (macro defined, TIMEOUT=16): req[0] with fifo_full=1 → timeout_pulse on the 16th stall cycle. Grant then moves to the next requester. Without the macro, the grant stays on 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   // Modulo-n increment; wraps explicitly so non-power-of-two counts work.
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational cyclic priority search: first set request at or after rr_ptr_i.
module rr_pick #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
   output logic [$clog2(NUM_REQ)-1:0] winner_o,
   output logic                       any_req_o
);

   localparam int unsigned IDW = $clog2(NUM_REQ);

   always_comb begin
      winner_o  = '0;
      any_req_o = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         int unsigned idx;
         idx = 32'(rr_ptr_i) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!any_req_o && req_i[IDW'(idx)]) begin
            winner_o  = IDW'(idx);
            any_req_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ producers.
// Optional full-stall forced release: define FIFO_WR_ARB_FULL_TIMEOUT_EN.
module fifo_wr_arb
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_BURST = 4
`ifdef FIFO_WR_ARB_FULL_TIMEOUT_EN
  ,parameter int unsigned TIMEOUT   = 16
`endif
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]         ack,
   input  logic                       fifo_full,
   output logic                       fifo_w_EN,
   output logic                       fifo_inDvalid,
   output logic [WIDTH-1:0]           fifo_data,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy
`ifdef FIFO_WR_ARB_FULL_TIMEOUT_EN
  ,output logic                       timeout_pulse
`endif
);

   localparam int unsigned IDW  = $clog2(NUM_REQ);
   localparam int unsigned CNTW = $clog2(MAX_BURST + 1);

   arb_state_t      state_q, state_d;
   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]  grant_q, grant_d;
   logic [CNTW-1:0] burst_cnt_q, burst_cnt_d;

   logic [IDW-1:0]   winner;
   logic             any_req;
   logic             req_g;
   logic             write;
   logic             release_c;
   logic [WIDTH-1:0] slices [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
      assign slices[g] = req_data[g*WIDTH +: WIDTH];
   end

   rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .req_i     (req),
      .rr_ptr_i  (rr_ptr_q),
      .winner_o  (winner),
      .any_req_o (any_req)
   );

`ifdef FIFO_WR_ARB_FULL_TIMEOUT_EN
   localparam int unsigned STW = $clog2(TIMEOUT + 1);
   logic [STW-1:0] stall_q, stall_d;
   logic           stall;
   logic           timeout_c;

   // Consecutive full-stall cycles of the current owner.
   always_comb begin
      stall     = (state_q == BURST) && req_g && fifo_full;
      timeout_c = stall && (stall_q == STW'(TIMEOUT - 1));
      stall_d   = '0;
      if (stall && !timeout_c) stall_d = stall_q + STW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
   end

   assign timeout_pulse = timeout_c && !rst;
`else
   logic timeout_c;
   assign timeout_c = 1'b0;
`endif

   // Next-state and write decode.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      burst_cnt_d = burst_cnt_q;
      req_g       = req[grant_q];
      write       = 1'b0;
      release_c   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d     = winner;
               burst_cnt_d = '0;
               state_d     = BURST;
            end
         end
         BURST: begin
            write = req_g && !fifo_full && !rst;
            if (write) burst_cnt_d = burst_cnt_q + CNTW'(1);
            release_c = !req_g || timeout_c ||
                        (write && (burst_cnt_q == CNTW'(MAX_BURST - 1)));
            if (release_c) begin
               state_d     = IDLE;
               burst_cnt_d = '0;
               rr_ptr_d    = IDW'(rr_next(32'(grant_q), NUM_REQ));
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   always_comb begin
      ack          = '0;
      ack[grant_q] = write;
   end

   assign fifo_w_EN     = write;
   assign fifo_inDvalid = write;
   assign busy          = (state_q == BURST);
   assign grant_id      = grant_q;
   assign fifo_data     = busy ? slices[grant_q] : '0;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed self-checking bench for fifo_wr_arb (NUM_REQ=4, WIDTH=8, MAX_BURST=4).
module tb_fifo_wr_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  ack;
   logic        fifo_full;
   logic        fifo_w_EN;
   logic        fifo_inDvalid;
   logic [7:0]  fifo_data;
   logic [1:0]  grant_id;
   logic        busy;
`ifdef FIFO_WR_ARB_FULL_TIMEOUT_EN
   logic        timeout_pulse;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fifo_wr_arb #(
      .NUM_REQ   (4),
      .WIDTH     (8),
      .MAX_BURST (4)
`ifdef FIFO_WR_ARB_FULL_TIMEOUT_EN
     ,.TIMEOUT   (16)
`endif
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .req_data      (req_data),
      .ack           (ack),
      .fifo_full     (fifo_full),
      .fifo_w_EN     (fifo_w_EN),
      .fifo_inDvalid (fifo_inDvalid),
      .fifo_data     (fifo_data),
      .grant_id      (grant_id),
      .busy          (busy)
`ifdef FIFO_WR_ARB_FULL_TIMEOUT_EN
     ,.timeout_pulse (timeout_pulse)
`endif
   );

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 4'b0000; fifo_full = 1'b0;
      nxt();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 4'b1111; fifo_full = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_checks++;
         if (ack !== 4'b0000 || fifo_w_EN !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_hold cyc%0d got ack=%b wen=%b busy=%b gid=%0d exp 0000/0/0/0",
                     c, ack, fifo_w_EN, busy, grant_id);
         end
         nxt();
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ack !== 4'b0000 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_arb_cycle got ack=%b busy=%b exp 0000/0", ack, busy);
      end
      nxt();
      @(negedge clk);
      n_checks++;
      if (ack !== 4'b0001 || fifo_w_EN !== 1'b1 || fifo_inDvalid !== 1'b1 || fifo_data !== 8'h11) begin
         n_fail++;
         $display("FAIL reset_first_ack got ack=%b wen=%b dv=%b data=%h exp 0001/1/1/11",
                  ack, fifo_w_EN, fifo_inDvalid, fifo_data);
      end
      nxt();
   endtask

   task automatic test_fairness();
      int acks [4];
      logic [3:0] exp_ack;
      logic [7:0] exp_data;
      logic       exp_busy;
      for (int p = 0; p < 4; p++) acks[p] = 0;
      do_reset();
      req = 4'b1111;
      for (int c = 0; c < 20; c++) begin
         if (c % 5 == 0) begin
            exp_ack = 4'b0000; exp_busy = 1'b0; exp_data = 8'h00;
         end else begin
            exp_ack  = 4'b0001 << (c / 5);
            exp_busy = 1'b1;
            exp_data = 8'h11 * 8'((c / 5) + 1);
         end
         @(negedge clk);
         for (int p = 0; p < 4; p++) if (ack[p]) acks[p]++;
         n_checks++;
         if (ack !== exp_ack || busy !== exp_busy || fifo_data !== exp_data) begin
            n_fail++;
            $display("FAIL fair cyc%0d got ack=%b busy=%b data=%h exp %b/%b/%h",
                     c, ack, busy, fifo_data, exp_ack, exp_busy, exp_data);
         end
         nxt();
      end
      for (int p = 0; p < 4; p++) begin
         n_checks++;
         if (acks[p] != 4) begin
            n_fail++;
            $display("FAIL fair_count p%0d got=%0d exp=4", p, acks[p]);
         end
      end
   endtask

   task automatic test_early_drop();
      int writes = 0;
      do_reset();
      req = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (fifo_w_EN) writes++;
         nxt();
      end
      req = 4'b0000;
      @(negedge clk);
      if (fifo_w_EN) writes++;
      n_checks++;
      if (ack !== 4'b0000 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL drop_release_cycle got ack=%b busy=%b exp 0000/1", ack, busy);
      end
      nxt();
      req = 4'b0101;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || writes != 2) begin
         n_fail++;
         $display("FAIL drop_idle got busy=%b writes=%0d exp 0/2", busy, writes);
      end
      nxt();
      @(negedge clk);
      n_checks++;
      if (grant_id !== 2'd0 || ack !== 4'b0001) begin
         n_fail++;
         $display("FAIL drop_wrap got gid=%0d ack=%b exp 0/0001", grant_id, ack);
      end
      nxt();
   endtask

   task automatic test_full_stall();
      int writes = 0;
      do_reset();
      req = 4'b0010;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (fifo_w_EN) writes++;
         nxt();
      end
      fifo_full = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_checks++;
         if (fifo_w_EN !== 1'b0 || ack !== 4'b0000 || grant_id !== 2'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall cyc%0d got wen=%b ack=%b gid=%0d busy=%b exp 0/0000/1/1",
                     c, fifo_w_EN, ack, grant_id, busy);
         end
         nxt();
      end
      fifo_full = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         if (fifo_w_EN) writes++;
         n_checks++;
         if (ack !== 4'b0010 || fifo_data !== 8'h22) begin
            n_fail++;
            $display("FAIL stall_resume cyc%0d got ack=%b data=%h exp 0010/22", c, ack, fifo_data);
         end
         nxt();
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || writes != 4) begin
         n_fail++;
         $display("FAIL stall_done got busy=%b writes=%0d exp 0/4", busy, writes);
      end
      nxt();
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      req = 4'b0010;
      nxt();
      @(negedge clk);
      n_checks++;
      if (ack !== 4'b0010) begin
         n_fail++;
         $display("FAIL rmb_first_ack got ack=%b exp 0010", ack);
      end
      nxt();
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (fifo_w_EN !== 1'b0 || ack !== 4'b0000) begin
         n_fail++;
         $display("FAIL rmb_reset_cycle got wen=%b ack=%b exp 0/0000", fifo_w_EN, ack);
      end
      nxt();
      rst = 1'b0;
      req = 4'b1001;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || fifo_w_EN !== 1'b0 || grant_id !== 2'd0) begin
         n_fail++;
         $display("FAIL rmb_after got busy=%b wen=%b gid=%0d exp 0/0/0", busy, fifo_w_EN, grant_id);
      end
      nxt();
      @(negedge clk);
      n_checks++;
      if (grant_id !== 2'd0 || ack !== 4'b0001) begin
         n_fail++;
         $display("FAIL rmb_ptr got gid=%0d ack=%b exp 0/0001", grant_id, ack);
      end
      nxt();
   endtask

   task automatic test_timeout();
      do_reset();
      req = 4'b0011;
      fifo_full = 1'b1;
      nxt();
`ifdef FIFO_WR_ARB_FULL_TIMEOUT_EN
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         n_checks++;
         if (timeout_pulse !== (c == 16) || ack !== 4'b0000 || grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL timeout stall%0d got pulse=%b ack=%b gid=%0d exp %b/0000/0",
                     c, timeout_pulse, ack, grant_id, (c == 16));
         end
         nxt();
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || timeout_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_idle got busy=%b pulse=%b exp 0/0", busy, timeout_pulse);
      end
      nxt();
      @(negedge clk);
      n_checks++;
      if (grant_id !== 2'd1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_next got gid=%0d busy=%b exp 1/1", grant_id, busy);
      end
      nxt();
`else
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         n_checks++;
         if (ack !== 4'b0000 || grant_id !== 2'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL hold stall%0d got ack=%b gid=%0d busy=%b exp 0000/0/1",
                     c, ack, grant_id, busy);
         end
         nxt();
      end
`endif
      fifo_full = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = 4'b0000; fifo_full = 1'b0;
      req_data = {8'h44, 8'h33, 8'h22, 8'h11};
      nxt();
      test_reset();
      test_fairness();
      test_early_drop();
      test_full_stall();
      test_reset_mid_burst();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
